rd_req_arb_rr: RTL and testbench

RD_REQ_ARB_RR -- requirements
Module: rd_req_arb_rr

---
 rtl/rd_req_arb_rr.sv | 147 ++++++++++++++
 tb/tb_rd_req_arb_rr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_req_arb_rr.sv
// Read-request arbiter: picks one eligible interrupt group (round-robin or
// fixed priority), issues a registered rd_req with the group id, and waits
// for rd_req_ack with an optional timeout that abandons the request.
module rd_req_arb_rr #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MODE    = 0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_interrupt,
    input  logic [N_REQ-1:0] i_enable,
    input  logic             rd_req_ack,
    output logic             rd_req,
    output logic [ID_W-1:0]  rd_slave_id,
    output logic             timeout_err
);

    localparam int unsigned     CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam bit               FIXED   = (MODE == 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_d;
    logic [ID_W-1:0]   id_d;
    logic              terr_d;

    logic [N_REQ-1:0]  eligible_c;
    logic [ID_W-1:0]   winner_c;
    logic [ID_W-1:0]   scan_idx_c;
    logic              found_c;
    logic [ID_W-1:0]   ptr_adv_c;

    // Groups that are both requesting and enabled this cycle
    assign eligible_c = i_interrupt & i_enable;

    // Winner search: upward from ptr with wrap (round-robin) or from index 0 (fixed)
    always_comb begin
        winner_c   = '0;
        scan_idx_c = '0;
        found_c    = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (FIXED) begin
                scan_idx_c = ID_W'(k);
            end else begin
                scan_idx_c = ID_W'((32'(ptr_q) + k) % N_REQ);
            end
            if (!found_c && eligible_c[scan_idx_c]) begin
                found_c  = 1'b1;
                winner_c = scan_idx_c;
            end
        end
    end

    // Pointer moves to the group just after the one that was served
    assign ptr_adv_c = (win_q == LAST_ID) ? '0 : win_q + ID_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        req_d   = rd_req;
        id_d    = rd_slave_id;
        terr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|eligible_c) begin
                    win_d   = winner_c;
                    state_d = REQUEST;
                end
            end

            REQUEST: begin
                req_d   = 1'b1;
                id_d    = win_q;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (rd_req_ack) begin
                    // Ack wins over a coincident timeout
                    req_d   = 1'b0;
                    id_d    = '0;
                    ptr_d   = ptr_adv_c;
                    state_d = IDLE;
                end else if (TO_EN) begin
                    if (cnt_q == TO_LAST) begin
                        req_d   = 1'b0;
                        id_d    = '0;
                        terr_d  = 1'b1;
                        ptr_d   = ptr_adv_c;
                        state_d = IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                req_d   = 1'b0;
                id_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, arbitration context and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            rd_req      <= 1'b0;
            rd_slave_id <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            rd_req      <= req_d;
            rd_slave_id <= id_d;
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_rd_req_arb_rr.sv
// Bench for rd_req_arb_rr: one round-robin and one fixed-priority instance
// sharing stimulus, directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_rd_req_arb_rr;

    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] intr;
    logic [3:0] en;
    logic       ack;
    logic       req0, terr0, req1, terr1;
    logic [1:0] id0, id1;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;   // 0 none, 1 follow dut0, 2 follow dut1, 3 random

    always #5 clk = ~clk;

    rd_req_arb_rr #(.N_REQ(4), .ID_W(2), .MODE(0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_interrupt(intr), .i_enable(en),
        .rd_req_ack(ack), .rd_req(req0), .rd_slave_id(id0), .timeout_err(terr0));

    rd_req_arb_rr #(.N_REQ(4), .ID_W(2), .MODE(1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_interrupt(intr), .i_enable(en),
        .rd_req_ack(ack), .rd_req(req1), .rd_slave_id(id1), .timeout_err(terr1));

    // Reference model: phase 0 = no request, 1 = winner chosen, 2 = request outstanding
    int         m_phase[2] = '{0, 0};
    int         m_win[2]   = '{0, 0};
    int         m_ptr[2]   = '{0, 0};
    int         m_held[2]  = '{0, 0};
    logic       m_req[2]   = '{1'b0, 1'b0};
    logic [1:0] m_id[2]    = '{2'd0, 2'd0};
    logic       m_terr[2]  = '{1'b0, 1'b0};

    function automatic int pick(input logic [3:0] elig, input int start, input int fixed);
        int s;
        int j;
        s = (fixed != 0) ? 0 : start;
        for (int k = 0; k < N; k++) begin
            j = (s + k) % N;
            if (((elig >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_terr[d] = 1'b0;
            if (!rst_n) begin
                m_phase[d] = 0; m_ptr[d] = 0; m_win[d] = 0; m_held[d] = 0;
                m_req[d] = 1'b0; m_id[d] = 2'd0;
            end else if (m_phase[d] == 0) begin
                if ((intr & en) != 4'd0) begin
                    m_win[d]   = pick(intr & en, m_ptr[d], d);
                    m_phase[d] = 1;
                end
            end else if (m_phase[d] == 1) begin
                m_req[d] = 1'b1; m_id[d] = 2'(m_win[d]); m_held[d] = 0; m_phase[d] = 2;
            end else begin
                m_held[d]++;
                if (ack || m_held[d] == TO) begin
                    m_terr[d]  = !ack;
                    m_req[d]   = 1'b0;
                    m_id[d]    = 2'd0;
                    m_ptr[d]   = (m_win[d] + 1) % N;
                    m_phase[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        case (ack_mode)
            0: ack = 1'b0;
            1: ack = req0;
            2: ack = req1;
            default: ack = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        intr  = 4'd0;
        en    = 4'hF;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Waits for the next rising edge of rd_req on the chosen instance; gid=-1 if none
    task automatic wait_grant(input int which, input int budget,
                              output int gid, output int cyc, output int terrs);
        logic prev, cur;
        bit   done;
        prev  = (which == 0) ? req0 : req1;
        gid   = -1; cyc = 0; terrs = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
            cur = (which == 0) ? req0 : req1;
            if ((which == 0) ? terr0 : terr1) terrs++;
            if (cur && !prev) begin
                done = 1'b1;
                gid  = (which == 0) ? int'(id0) : int'(id1);
            end
            prev = cur;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; intr = 4'hF; en = 4'hF; ack_mode = 3;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({req0, id0, terr0} !== 4'b0) begin
            errors++; $display("FAIL reset_dut0: got %b expected 0000", {req0, id0, terr0});
        end
        checks++;
        if ({req1, id1, terr1} !== 4'b0) begin
            errors++; $display("FAIL reset_dut1: got %b expected 0000", {req1, id1, terr1});
        end
    endtask

    task automatic test_rr_sequence();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        int gid, cyc, terrs, tsum;
        do_reset();
        intr = 4'hF; en = 4'hF; ack_mode = 1; tsum = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(0, 20, gid, cyc, terrs);
            tsum += terrs;
            checks++;
            if (gid !== exp_ids[g]) begin
                errors++; $display("FAIL rr_seq_id[%0d]: got %0d expected %0d", g, gid, exp_ids[g]);
            end
            checks++;
            if (cyc !== ((g == 0) ? 2 : 3)) begin
                errors++; $display("FAIL rr_seq_latency[%0d]: got %0d expected %0d", g, cyc, (g == 0) ? 2 : 3);
            end
        end
        checks++;
        if (tsum !== 0) begin
            errors++; $display("FAIL rr_seq_timeout: got %0d pulses expected 0", tsum);
        end
    endtask

    task automatic test_rr_skip();
        int exp_ids[4] = '{1, 3, 1, 3};
        int gid, cyc, terrs;
        do_reset();
        intr = 4'b1010; en = 4'hF; ack_mode = 1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(0, 20, gid, cyc, terrs);
            checks++;
            if (gid !== exp_ids[g]) begin
                errors++; $display("FAIL rr_skip_id[%0d]: got %0d expected %0d", g, gid, exp_ids[g]);
            end
        end
    endtask

    task automatic test_fixed();
        int gid, cyc, terrs;
        do_reset();
        intr = 4'b1110; en = 4'hF; ack_mode = 2;
        for (int g = 0; g < 4; g++) begin
            wait_grant(1, 20, gid, cyc, terrs);
            checks++;
            if (gid !== 1) begin
                errors++; $display("FAIL fixed_id[%0d]: got %0d expected 1", g, gid);
            end
        end
    endtask

    task automatic test_timeout();
        int gid, cyc, terrs, high;
        do_reset();
        intr = 4'b0101; en = 4'hF; ack_mode = 0;
        wait_grant(0, 20, gid, cyc, terrs);
        checks++;
        if (gid !== 0) begin
            errors++; $display("FAIL timeout_first_id: got %0d expected 0", gid);
        end
        high = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!req0) break;
            high++;
        end
        checks++;
        if (high !== TO) begin
            errors++; $display("FAIL timeout_high_cycles: got %0d expected %0d", high, TO);
        end
        checks++;
        if (terr0 !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse: got %b expected 1", terr0);
        end
        tick();
        checks++;
        if (terr0 !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_width: got %b expected 0", terr0);
        end
        wait_grant(0, 20, gid, cyc, terrs);
        checks++;
        if (gid !== 2) begin
            errors++; $display("FAIL timeout_next_id: got %0d expected 2", gid);
        end
    endtask

    task automatic test_disabled();
        int seen;
        do_reset();
        intr = 4'b1000; en = 4'b0111; ack_mode = 3; seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (req0 || req1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL disabled_req: got %0d high cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int gid, cyc, terrs;
        do_reset();
        intr = 4'hF; en = 4'hF; ack_mode = 1;
        wait_grant(0, 20, gid, cyc, terrs);
        ack_mode = 0;
        wait_grant(0, 20, gid, cyc, terrs);
        checks++;
        if (gid !== 1) begin
            errors++; $display("FAIL rstmid_pre_id: got %0d expected 1", gid);
        end
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({req0, id0, terr0} !== 4'b0) begin
            errors++; $display("FAIL rstmid_drop: got %b expected 0000", {req0, id0, terr0});
        end
        rst_n = 1'b1; ack_mode = 1;
        wait_grant(0, 20, gid, cyc, terrs);
        checks++;
        if (gid !== 0) begin
            errors++; $display("FAIL rstmid_restart_id: got %0d expected 0", gid);
        end
    endtask

    task automatic test_random();
        do_reset();
        ack_mode = 3;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) intr = 4'($urandom);
            if ($urandom_range(0, 4) == 0) en = 4'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            checks++;
            if ({req0, id0, terr0} !== {m_req[0], m_id[0], m_terr[0]}) begin
                errors++;
                $display("FAIL random_dut0 cyc %0d: got req/id/terr %b expected %b",
                         c, {req0, id0, terr0}, {m_req[0], m_id[0], m_terr[0]});
            end
            checks++;
            if ({req1, id1, terr1} !== {m_req[1], m_id[1], m_terr[1]}) begin
                errors++;
                $display("FAIL random_dut1 cyc %0d: got req/id/terr %b expected %b",
                         c, {req1, id1, terr1}, {m_req[1], m_id[1], m_terr[1]});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        intr  = 4'd0;
        en    = 4'd0;
        ack   = 1'b0;
        test_reset();
        test_rr_sequence();
        test_rr_skip();
        test_fixed();
        test_timeout();
        test_disabled();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
